// File: rtl/ctrl_seq_if.sv
// Request/response and ctrl_bus signals for the control-sequence generator.
// The master side is the sequencer; the slave side is whoever requests runs and consumes the bus.
interface ctrl_seq_if #(
    parameter int LENWD = 16
);
    logic             req;
    logic [LENWD-1:0] len;
    logic             stall;
    logic             ack;
    logic             busy;
    logic             out_start;
    logic             out_valid;
    logic             out_stop;
    logic [LENWD-1:0] count;

    modport master (
        input  req, len, stall,
        output ack, busy, out_start, out_valid, out_stop, count
    );

    modport slave (
        output req, len, stall,
        input  ack, busy, out_start, out_valid, out_stop, count
    );
endinterface

// File: rtl/ctrl_seq.sv
// Control-sequence generator: start pulse, LEN stall-aware valid beats, stop pulse,
// with a fixed-depth delay line aligning the strobes to the downstream datapath.
module ctrl_seq #(
    parameter int LENWD   = 16,
    parameter int LATENCY = 0
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_seq_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [LENWD-1:0] ONE = {{(LENWD-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [LENWD-1:0] len_q, len_d;
    logic [LENWD-1:0] count_q, count_d;
    logic             ack_q, ack_d;
    logic [2:0]       raw;
    logic [2:0]       outStrobes;
    logic             lineBusy;
    logic             busy;

    assign busy = (state_q != IDLE) | lineBusy;

    // Last beat is detected one early against len_q-1, so count never has to exceed len_q.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req && !busy) begin
                    len_d   = bus.len;
                    count_d = '0;
                    ack_d   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (!bus.stall) begin
                    state_d = (len_q != '0) ? RUN : STOP;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    count_d = count_q + ONE;
                    if (count_q == len_q - ONE) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!bus.stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            ack_q   <= ack_d;
        end
    end

    // {start, valid, stop}; mutually exclusive because each decodes a distinct state.
    assign raw = {(state_q == START) && !bus.stall,
                  (state_q == RUN)   && !bus.stall,
                  (state_q == STOP)  && !bus.stall};

    generate
        if (LATENCY == 0) begin : g_noDelay
            assign outStrobes = raw;
            assign lineBusy   = 1'b0;
        end else begin : g_delay
            logic [2:0] line_q [LATENCY];

            // The line free-runs regardless of stall; only reset clears it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        line_q[i] <= 3'b000;
                    end
                end else begin
                    line_q[0] <= raw;
                    for (int i = 1; i < LATENCY; i++) begin
                        line_q[i] <= line_q[i-1];
                    end
                end
            end

            always_comb begin
                lineBusy = 1'b0;
                for (int i = 0; i < LATENCY; i++) begin
                    lineBusy = lineBusy | (|line_q[i]);
                end
            end

            assign outStrobes = line_q[LATENCY-1];
        end
    endgenerate

    assign bus.ack       = ack_q;
    assign bus.busy      = busy;
    assign bus.out_start = outStrobes[2];
    assign bus.out_valid = outStrobes[1];
    assign bus.out_stop  = outStrobes[0];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: three instances (LATENCY 0/1/2) share one stimulus stream,
// and each test checks the instance whose latency it targets, cycle by cycle.
module tb_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] len = '0;
    logic        stall = 1'b0;
    int          sel = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          validSeen = 0;
    int          stopSeen = 0;

    always #5 clk = ~clk;

    ctrl_seq_if #(.LENWD(16)) bus0 ();
    ctrl_seq_if #(.LENWD(16)) bus1 ();
    ctrl_seq_if #(.LENWD(16)) bus2 ();

    assign bus0.req = req;  assign bus0.len = len;  assign bus0.stall = stall;
    assign bus1.req = req;  assign bus1.len = len;  assign bus1.stall = stall;
    assign bus2.req = req;  assign bus2.len = len;  assign bus2.stall = stall;

    ctrl_seq #(.LENWD(16), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ctrl_seq #(.LENWD(16), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ctrl_seq #(.LENWD(16), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Flags are packed {ack, busy, out_start, out_valid, out_stop}.
    logic [4:0]  flags0, flags1, flags2, obs;
    logic [15:0] obsCount;
    assign flags0 = {bus0.ack, bus0.busy, bus0.out_start, bus0.out_valid, bus0.out_stop};
    assign flags1 = {bus1.ack, bus1.busy, bus1.out_start, bus1.out_valid, bus1.out_stop};
    assign flags2 = {bus2.ack, bus2.busy, bus2.out_start, bus2.out_valid, bus2.out_stop};

    always_comb begin
        obs      = flags0;
        obsCount = bus0.count;
        case (sel)
            1: begin obs = flags1; obsCount = bus1.count; end
            2: begin obs = flags2; obsCount = bus2.count; end
            default: begin obs = flags0; obsCount = bus0.count; end
        endcase
    end

    logic [4:0] exp1 [0:8]  = '{5'b00000, 5'b11100, 5'b01010, 5'b01010, 5'b01010,
                                5'b01010, 5'b01001, 5'b00000, 5'b00000};
    logic [4:0] exp2 [0:10] = '{5'b00000, 5'b11000, 5'b01000, 5'b01100, 5'b01010, 5'b01000,
                                5'b01000, 5'b01010, 5'b01010, 5'b01001, 5'b00000};
    logic [4:0] exp3 [0:4]  = '{5'b00000, 5'b11100, 5'b01001, 5'b00000, 5'b00000};
    logic [4:0] exp4 [0:14] = '{5'b00000, 5'b11100, 5'b01010, 5'b01010, 5'b01001,
                                5'b00000, 5'b11100, 5'b01010, 5'b01010, 5'b01001,
                                5'b00000, 5'b11100, 5'b01010, 5'b01010, 5'b01001};
    logic [4:0] exp5 [0:10] = '{5'b00000, 5'b11000, 5'b01100, 5'b01010, 5'b01010, 5'b00000,
                                5'b00000, 5'b11000, 5'b01100, 5'b01010, 5'b01010};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, check on the falling edge, then step past the next rising edge.
    task automatic applyStimulus(input logic r, input logic rq, input logic [15:0] l,
                                 input logic st, input logic [4:0] expFlags,
                                 input string tag, input int k);
        rst   = r;
        req   = rq;
        len   = l;
        stall = st;
        @(negedge clk);
        checkOutput($sformatf("%s c%0d flags", tag, k), {27'd0, obs}, {27'd0, expFlags});
        checkOutput($sformatf("%s c%0d onehot0", tag, k), {31'd0, $countones(flags0[2:0]) <= 1}, 32'd1);
        checkOutput($sformatf("%s c%0d onehot1", tag, k), {31'd0, $countones(flags1[2:0]) <= 1}, 32'd1);
        checkOutput($sformatf("%s c%0d onehot2", tag, k), {31'd0, $countones(flags2[2:0]) <= 1}, 32'd1);
        if (obs[1]) validSeen++;
        if (obs[0]) stopSeen++;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset flags0", {27'd0, flags0}, 32'd0);
        checkOutput("reset flags1", {27'd0, flags1}, 32'd0);
        checkOutput("reset flags2", {27'd0, flags2}, 32'd0);
        checkOutput("reset count0", {16'd0, bus0.count}, 32'd0);
        checkOutput("reset count2", {16'd0, bus2.count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        validSeen = 0;
        stopSeen = 0;
    endtask

    task automatic checkCount(input string tag, input logic [15:0] expected);
        req = 1'b0;
        @(negedge clk);
        checkOutput(tag, {16'd0, obsCount}, {16'd0, expected});
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;

        doReset();
        sel = 0;
        for (int k = 0; k <= 8; k++) applyStimulus(1'b0, k == 0, 16'd4, 1'b0, exp1[k], "len4", k);
        checkCount("len4 count", 16'd4);
        checkOutput("len4 valids", validSeen, 32'd4);

        doReset();
        sel = 2;
        for (int k = 0; k <= 10; k++)
            applyStimulus(1'b0, k == 0, 16'd3, (k == 3) || (k == 4), exp2[k], "stall", k);
        checkCount("stall count", 16'd3);
        checkOutput("stall valids", validSeen, 32'd3);

        doReset();
        sel = 0;
        for (int k = 0; k <= 4; k++) applyStimulus(1'b0, k == 0, 16'd0, 1'b0, exp3[k], "len0", k);
        checkCount("len0 count", 16'd0);
        checkOutput("len0 valids", validSeen, 32'd0);

        doReset();
        sel = 0;
        for (int k = 0; k <= 14; k++)
            applyStimulus(1'b0, 1'b1, (k >= 2 && k <= 4) ? 16'd7 : 16'd2, 1'b0, exp4[k], "b2b", k);
        checkCount("b2b count", 16'd2);
        checkOutput("b2b valids", validSeen, 32'd6);

        doReset();
        sel = 1;
        for (int k = 0; k <= 10; k++)
            applyStimulus(k == 4, (k == 0) || (k == 6), 16'd10, 1'b0, exp5[k], "abort", k);
        checkOutput("abort stops", stopSeen, 32'd0);
        checkCount("abort count", 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
